// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit multi-cycle core: widths, opcodes, fetch payload.
package cpu_pkg;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 8;

  localparam logic [3:0] OPC_J   = 4'b1000;
  localparam logic [3:0] OPC_JAL = 4'b1001;
  localparam logic [3:0] OPC_BEQ = 4'b1100;
  localparam logic [3:0] OPC_BNE = 4'b1101;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Branches are PC-relative, jumps carry an absolute target; both wrap mod 256.
  function automatic logic [PC_W-1:0] redirect_target(input logic            rel,
                                                       input logic [PC_W-1:0] pc,
                                                       input logic [PC_W-1:0] off);
    return rel ? PC_W'(pc + off) : off;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} entries; flush empties it in one cycle.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush_i,
  input  logic                                push_i,
  input  fetch_entry_t                        push_data_i,
  input  logic                                pop_i,
  output logic [$clog2(DEPTH):0]              count_o,
  output fetch_entry_t                        head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues imem reads under a credit rule, buffers results for decode.
// Optional performance counters are enabled by defining IFETCH_PERF_EN.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = 8'h00,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               inst_valid,
  output logic [INSTR_W-1:0] inst_data,
  output logic [PC_W-1:0]    inst_pc,
  input  logic               inst_ready,
  input  logic               redirect_valid,
  input  logic               redirect_rel,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic [PC_W-1:0]    redirect_off
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0]        perf_fetch_cnt,
  output logic [15:0]        perf_flush_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CRD_W = CNT_W + 1;

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  pend_pc_q,  pend_pc_d;
  logic             pending_q,  pending_d;
  logic             kill_q,     kill_d;

  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_head;
  fetch_entry_t     push_entry;
  logic             pop;
  logic             push;
  logic [CRD_W-1:0] credit_used;

  // Redirect hides the head and blocks the pop so nothing wrong-path reaches decode.
  assign inst_valid  = (fifo_count != '0) && !redirect_valid;
  assign pop         = inst_valid && inst_ready;
  assign credit_used = CRD_W'(pending_q) + CRD_W'(fifo_count) - CRD_W'(pop);
  assign imem_req    = !rst && !redirect_valid && (credit_used < CRD_W'(FIFO_DEPTH));
  assign imem_addr   = fetch_pc_q;
  assign push        = pending_q && !kill_q && !redirect_valid;
  assign push_entry  = '{pc: pend_pc_q, instr: imem_rdata};
  assign inst_data   = fifo_head.instr;
  assign inst_pc     = fifo_head.pc;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    pending_d  = imem_req;
    kill_d     = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = redirect_target(redirect_rel, redirect_pc, redirect_off);
      kill_d     = pending_q;
    end else if (imem_req) begin
      fetch_pc_d = fetch_pc_q + PC_W'(1);
      pend_pc_d  = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
      pending_q  <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      pending_q  <= pending_d;
      kill_q     <= kill_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (redirect_valid),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .count_o    (fifo_count),
    .head_o     (fifo_head)
  );

`ifdef IFETCH_PERF_EN
  logic [15:0] perf_fetch_q, perf_fetch_d;
  logic [15:0] perf_flush_q, perf_flush_d;

  // Saturating event counters.
  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_flush_d = perf_flush_q;
    if (pop && perf_fetch_q != 16'hFFFF)            perf_fetch_d = perf_fetch_q + 16'd1;
    if (redirect_valid && perf_flush_q != 16'hFFFF) perf_flush_d = perf_flush_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
